uparc_fetch_pq: RTL

Parametrised instruction prefetch queue for the Ultiparc core. It replaces the single-entry fetch path between the I-Port and the decode stage. The block streams sequential instruction reads over the I-Port into a DEPTH-entry FIFO. Each entry is tagged with its PC and error status, so decode can consume one instruction per cycle while the bus has wait states. Jump and exception redirects flush the queue; a bus read already in flight is allowed to finish and its result is dropped.

---
 rtl/uparc_fetch_pq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uparc_fetch_pq.sv
// Ultiparc instruction prefetch queue.
// Streams sequential I-Port reads into a tagged FIFO for decode.
module uparc_fetch_pq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_WIDTH-1:0]      o_IAddr,
  output logic                       o_IRdC,
  input  logic [DATA_WIDTH-1:0]      i_IData,
  input  logic                       i_IRdy,
  input  logic                       i_IErr,
  input  logic                       i_redirect,
  input  logic [ADDR_WIDTH-1:0]      i_redirect_addr,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_instr,
  output logic [ADDR_WIDTH-1:0]      o_pc,
  output logic                       o_bus_error,
  output logic                       o_addr_error,
  input  logic                       i_take,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  berr;
    logic                  aerr;
  } ent_t;

  ent_t                  mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] fpc;
  logic                  busy;
  logic                  discard;
  logic                  halt;

  logic                  done;
  logic                  bus_ok;
  logic                  pop;
  logic                  mis_enq;
  logic                  enq;
  logic                  issue;
  logic                  halt_nxt;
  logic [CW-1:0]         count_pop;
  logic [CW-1:0]         count_nxt;
  logic [ADDR_WIDTH-1:0] fpc_nxt;
  ent_t                  ent_in;

  // Next-state decisions for queue, fetch PC and bus request
  always_comb begin
    done      = busy & (i_IRdy | i_IErr);
    bus_ok    = done & ~discard & ~i_redirect;
    pop       = i_take & (count != '0) & ~i_redirect;
    count_pop = count - CW'(pop);
    mis_enq   = ~busy & ~halt & (fpc[1:0] != 2'b00) &
                ~i_redirect & (count_pop < CW'(DEPTH));
    enq       = bus_ok | mis_enq;
    count_nxt = i_redirect ? '0 : count_pop + CW'(enq);
    fpc_nxt   = fpc;
    unique case (1'b1)
      i_redirect:         fpc_nxt = i_redirect_addr;
      bus_ok & ~i_IErr:   fpc_nxt = fpc + ADDR_WIDTH'(4);
      default:            fpc_nxt = fpc;
    endcase
    halt_nxt  = ~i_redirect &
                (halt | (bus_ok & i_IErr) | mis_enq);
    issue     = (~busy | done) & ~halt_nxt &
                (fpc_nxt[1:0] == 2'b00) &
                (count_nxt < CW'(DEPTH));
    ent_in    = '0;
    if (mis_enq) begin
      ent_in.pc   = fpc;
      ent_in.aerr = 1'b1;
    end else begin
      ent_in.instr = i_IData;
      ent_in.pc    = fpc;
      ent_in.berr  = i_IErr;
    end
  end

  // Control state: pointers, count, fetch PC and bus handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      fpc     <= RESET_ADDR;
      busy    <= 1'b0;
      discard <= 1'b0;
      halt    <= 1'b0;
      o_IAddr <= RESET_ADDR;
    end else begin
      rd_ptr  <= i_redirect ? '0 : rd_ptr + PW'(pop);
      wr_ptr  <= i_redirect ? '0 : wr_ptr + PW'(enq);
      count   <= count_nxt;
      fpc     <= fpc_nxt;
      halt    <= halt_nxt;
      busy    <= issue | (busy & ~done);
      if (done)
        discard <= 1'b0;
      else if (i_redirect & busy)
        discard <= 1'b1;
      if (issue)
        o_IAddr <= fpc_nxt;
    end
  end

  // Entry storage, cleared on reset so head outputs start at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (enq) begin
      mem[wr_ptr] <= ent_in;
    end
  end

  assign o_IRdC       = busy;
  assign o_valid      = (count != '0);
  assign o_count      = count;
  assign o_instr      = mem[rd_ptr].instr;
  assign o_pc         = mem[rd_ptr].pc;
  assign o_bus_error  = mem[rd_ptr].berr;
  assign o_addr_error = mem[rd_ptr].aerr;

endmodule
